// File: rtl/cpu_mc_control.sv
// Multicycle control FSM for the ARM-subset CPU (DP/MEM/B) with memory ready handshake and bus timeout.
// Optional feature: define CPU_MC_CMP_EN to decode cmd 1010 as CMP (SUB, flags only, no writeback).
module cpu_mc_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        fault
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
    } state_t;

    state_t           state, next;
    logic [3:0]       flags;
    logic             condex;
    logic [TMO_W-1:0] wait_cnt;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       rd_pc;
    logic       mem_state;
    logic       timeout;
    logic [1:0] alu_dp;
    logic       cmd_ok;
    logic       cmd_arith;
    logic       cmd_cmp;
    logic       dp_wr;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign cmd          = Instr[24:21];
    assign rd_pc        = (Instr[15:12] == 4'hf);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy && !z;
            4'h9:    return !cy || z;
            4'ha:    return n == v;
            4'hb:    return n != v;
            4'hc:    return !z && (n == v);
            4'hd:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        alu_dp    = 2'b00;
        cmd_ok    = 1'b0;
        cmd_arith = 1'b0;
        cmd_cmp   = 1'b0;
        case (cmd)
            4'b0100: begin alu_dp = 2'b00; cmd_ok = 1'b1; cmd_arith = 1'b1; end
            4'b0010: begin alu_dp = 2'b01; cmd_ok = 1'b1; cmd_arith = 1'b1; end
            4'b0000: begin alu_dp = 2'b10; cmd_ok = 1'b1; end
            4'b1100: begin alu_dp = 2'b11; cmd_ok = 1'b1; end
`ifdef CPU_MC_CMP_EN
            4'b1010: begin alu_dp = 2'b01; cmd_ok = 1'b1; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Unsupported commands and CMP complete the ALUWB cycle without writing anything back.
    assign dp_wr     = condex && cmd_ok && !cmd_cmp;
    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout   = mem_state && !mem_ready && (wait_cnt == TMO_W'(MEM_TIMEOUT));

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  if (mem_ready) next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   next = Instr[25] ? S_EXECI : S_EXECR;
                    2'b01:   next = S_MEMADR;
                    2'b10:   next = S_BRANCH;
                    default: next = S_FETCH;
                endcase
            end
            S_MEMADR: next = Instr[20] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next = S_MEMWB;
            S_MEMWR:  if (mem_ready) next = S_FETCH;
            S_EXECR:  next = S_ALUWB;
            S_EXECI:  next = S_ALUWB;
            S_MEMWB:  next = S_FETCH;
            S_ALUWB:  next = S_FETCH;
            S_BRANCH: next = S_FETCH;
            S_FAULT:  next = S_FAULT;
            default:  next = S_FETCH;
        endcase
        if (timeout) next = S_FAULT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            flags    <= 4'h0;
            condex   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= next;
            // Every state change restarts the count, so each memory state begins at zero.
            if (next != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + TMO_W'(1);
            if (state == S_DECODE)
                condex <= cond_pass(Instr[31:28], flags);
            if ((state == S_EXECR || state == S_EXECI) && condex && cmd_ok && (Instr[20] || cmd_cmp)) begin
                flags[3:2] <= ALUFlags[3:2];
                if (cmd_arith) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 2'b00;
        fault      = 1'b0;
        if (state != S_FAULT) begin
            ImmSrc = op;
            RegSrc = {op == 2'b01, op == 2'b10};
        end
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = condex;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condex && !rd_pc;
                PCWrite   = condex && rd_pc;
            end
            S_EXECR: ALUControl = alu_dp;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dp;
            end
            S_ALUWB: begin
                RegWrite = dp_wr && !rd_pc;
                PCWrite  = dp_wr && rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        // Reset gates the outputs combinationally so an in-flight write strobe drops at once.
        if (!rst) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
            ALUControl = 2'b00;
            fault      = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_mc_control.sv
// Scoreboard bench for cpu_mc_control: instruction-level reference model queues per-cycle expectations.
module tb_cpu_mc_control;

    localparam int MEM_TIMEOUT = 16;
`ifdef CPU_MC_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, fault;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    cpu_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, memwrite, irwrite, pcwrite, regwrite, adrsrc, alusrca;
        logic [1:0] alusrcb, resultsrc, immsrc, regsrc, aluctl;
        logic       fault;
    } ov_t;

    ov_t   act;
    assign act = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, fault};

    ov_t   exp_q[$];
    ov_t   care_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;

    logic [31:0] cur_instr = 32'h0;
    logic [3:0]  cur_af = 4'h0;
    logic [3:0]  mflags = 4'h0;
    bit          rdy_rand = 1'b0;

    ov_t   mon_e, mon_c;
    string mon_n;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_c = care_q.pop_front();
            mon_n = nm_q.pop_front();
            total++;
            if (((act ^ mon_e) & mon_c) != '0) begin
                bad++;
                $display("FAIL %s: got=%05h want=%05h care=%05h t=%0t", mon_n, act, mon_e, mon_c, $time);
            end
        end
    end

    // Reference model: ARM condition table, cmd classes, and flag rules.
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] & ~f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = ~f[2] & (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return c[0] ? ~r : r;
    endfunction

    // 0 unsupported, 1 logical, 2 arithmetic, 3 compare
    function automatic int m_kind(input logic [3:0] cmd);
        if (cmd == 4'b0100 || cmd == 4'b0010) return 2;
        if (cmd == 4'b0000 || cmd == 4'b1100) return 1;
        if (cmd == 4'b1010 && CMP_EN) return 3;
        return 0;
    endfunction

    function automatic logic [1:0] m_aluctl(input logic [3:0] cmd);
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        if (cmd == 4'b1010 && CMP_EN) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ov_t bse();
        ov_t o = '0;
        o.immsrc = cur_instr[27:26];
        o.regsrc = {cur_instr[27:26] == 2'b01, cur_instr[27:26] == 2'b10};
        return o;
    endfunction

    function automatic ov_t cb();
        ov_t c = '0;
        c.mem_req = 1'b1; c.memwrite = 1'b1; c.irwrite = 1'b1; c.pcwrite = 1'b1;
        c.regwrite = 1'b1; c.immsrc = 2'b11; c.regsrc = 2'b11; c.fault = 1'b1;
        return c;
    endfunction

    function automatic logic rnd_rdy();
        return rdy_rand ? 1'($urandom % 2) : 1'b1;
    endfunction

    function automatic void fetch_exp(input logic r, output ov_t v, output ov_t c);
        v = bse(); c = cb();
        v.mem_req = 1'b1; v.irwrite = r; v.pcwrite = r;
        v.alusrca = 1'b1; v.alusrcb = 2'b10; v.resultsrc = 2'b10;
        c.adrsrc = 1'b1; c.alusrca = 1'b1; c.alusrcb = 2'b11; c.resultsrc = 2'b11; c.aluctl = 2'b11;
    endfunction

    task automatic cyc(input logic rdy, input ov_t v, input ov_t c, input string n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = rdy;
        Instr = cur_instr;
        ALUFlags = cur_af;
        exp_q.push_back(v);
        care_q.push_back(c);
        nm_q.push_back(n);
    endtask

    task automatic rst_cyc(input int n);
        ov_t all;
        all = '1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            mem_ready = 1'($urandom % 2);
            exp_q.push_back('0);
            care_q.push_back(all);
            nm_q.push_back("reset");
        end
        mflags = 4'h0;
    endtask

    task automatic mem_phase(input int w, input ov_t v, input ov_t c, input string n);
        for (int k = 0; k < w; k++) cyc(1'b0, v, c, {n, "_wait"});
        cyc(1'b1, v, c, n);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int wf, input int wm);
        ov_t  v, c;
        logic ce, rd15, wr;
        int   kind;
        cur_instr = ins;
        cur_af = af;
        rd15 = (ins[15:12] == 4'hf);
        for (int k = 0; k < wf; k++) begin
            fetch_exp(1'b0, v, c);
            cyc(1'b0, v, c, "fetch_wait");
        end
        fetch_exp(1'b1, v, c);
        cyc(1'b1, v, c, "fetch");
        ce = m_cond(ins[31:28], mflags);
        v = bse(); c = cb();
        cyc(rnd_rdy(), v, c, "decode");
        case (ins[27:26])
            2'b01: begin
                v = bse(); c = cb();
                v.alusrcb = 2'b01;
                c.alusrca = 1'b1; c.alusrcb = 2'b11; c.aluctl = 2'b11;
                cyc(rnd_rdy(), v, c, "memadr");
                v = bse(); c = cb();
                v.mem_req = 1'b1; v.adrsrc = 1'b1; c.adrsrc = 1'b1;
                if (ins[20]) begin
                    mem_phase(wm, v, c, "memrd");
                    v = bse(); c = cb();
                    v.resultsrc = 2'b01; c.resultsrc = 2'b11;
                    v.regwrite = ce & ~rd15;
                    v.pcwrite = ce & rd15;
                    cyc(rnd_rdy(), v, c, "memwb");
                end else begin
                    v.memwrite = ce;
                    mem_phase(wm, v, c, "memwr");
                end
            end
            2'b00: begin
                kind = m_kind(ins[24:21]);
                v = bse(); c = cb();
                v.alusrcb = ins[25] ? 2'b01 : 2'b00;
                v.aluctl = m_aluctl(ins[24:21]);
                c.alusrca = 1'b1; c.alusrcb = 2'b11; c.aluctl = 2'b11;
                cyc(rnd_rdy(), v, c, "exec");
                if (ce && kind == 3) mflags = af;
                else if (ce && kind != 0 && ins[20]) begin
                    mflags[3:2] = af[3:2];
                    if (kind == 2) mflags[1:0] = af[1:0];
                end
                wr = ce && (kind == 1 || kind == 2);
                v = bse(); c = cb();
                v.regwrite = wr & ~rd15;
                v.pcwrite = wr & rd15;
                c.resultsrc = 2'b11;
                cyc(rnd_rdy(), v, c, "aluwb");
            end
            2'b10: begin
                v = bse(); c = cb();
                v.pcwrite = ce; v.resultsrc = 2'b10; c.resultsrc = 2'b11;
                cyc(rnd_rdy(), v, c, "branch");
            end
            default: ;
        endcase
    endtask

    function automatic int rnd_wait();
        return ($urandom % 8 == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        ins = $urandom;
        ins[31:28] = ($urandom % 2 == 1) ? 4'he : 4'($urandom_range(0, 14));
        case ($urandom % 6)
            0: ins[24:21] = 4'b0100;
            1: ins[24:21] = 4'b0010;
            2: ins[24:21] = 4'b0000;
            3: ins[24:21] = 4'b1100;
            4: ins[24:21] = 4'b1010;
            default: ;
        endcase
        if ($urandom % 8 == 0) ins[15:12] = 4'hf;
        return ins;
    endfunction

    initial begin
        ov_t v, c, fv, all;
        rst = 1'b0;
        mem_ready = 1'b0;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        all = '1;

        rst_cyc(3);
        run_instr(32'hE0821003, 4'h0, 0, 0);
        run_instr(32'hE5910004, 4'h0, 0, 3);
        run_instr(32'hE0500000, 4'b0100, 0, 0);
        run_instr(32'h1AFFFFFE, 4'h0, 0, 0);

        // STR interrupted by reset while the write is pending
        cur_instr = 32'hE5810000;
        fetch_exp(1'b1, v, c);
        cyc(1'b1, v, c, "str_fetch");
        v = bse(); c = cb();
        cyc(1'b1, v, c, "str_decode");
        v.alusrcb = 2'b01;
        c.alusrca = 1'b1; c.alusrcb = 2'b11; c.aluctl = 2'b11;
        cyc(1'b1, v, c, "str_memadr");
        v = bse(); c = cb();
        v.mem_req = 1'b1; v.adrsrc = 1'b1; v.memwrite = 1'b1; c.adrsrc = 1'b1;
        cyc(1'b0, v, c, "str_memwr");
        rst_cyc(2);
        run_instr(32'h1AFFFFFE, 4'h0, 0, 0);

        run_instr(32'hE0500000, 4'b0000, 0, 0);
        run_instr(32'h1AFFFFFE, 4'h0, 0, 0);
        run_instr(32'hE1510001, 4'b0100, 0, 0);
        run_instr(32'h0AFFFFFE, 4'h0, 0, 0);
        run_instr(32'hE5910004, 4'h0, MEM_TIMEOUT, MEM_TIMEOUT);

        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++)
            run_instr(rnd_instr(), 4'($urandom % 16), rnd_wait(), rnd_wait());

        // Fetch that never completes runs into the sticky fault state
        rst_cyc(2);
        cur_instr = 32'hE0821003;
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            fetch_exp(1'b0, v, c);
            cyc(1'b0, v, c, "tmo_fetch_wait");
        end
        fv = '0;
        fv.fault = 1'b1;
        for (int k = 0; k < 5; k++) cyc(1'($urandom % 2), fv, all, "fault_hold");
        rst_cyc(2);
        run_instr(32'hE0821003, 4'h0, 1, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
